// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, error-flag type and percentage helper for fifo_sync
package fifo_pkg;

  localparam int PERC_SCALE = 100;
  localparam int PERC_WIDTH = 7;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  // Truncating occupancy percentage; depth is a power of two so the divide is a shift.
  function automatic logic [PERC_WIDTH-1:0] f_perc(input logic [31:0] usedw, input int addr_bits);
    logic [31:0] scaled;
    scaled = (usedw * 32'(PERC_SCALE)) >> addr_bits;
    return scaled[PERC_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// rtl/fifo_sync_ram.sv - single write port storage array with registered or asynchronous read
module fifo_sync_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 4,
  parameter bit ASYNC_READ = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_BITS-1:0]  wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_BITS-1:0]  rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  if (ASYNC_READ) begin : g_async
    logic unused_rd;
    assign unused_rd = rst_i | rd_en_i;
    assign rd_data_o = mem_q[rd_addr_i];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_data_q <= '0;
      end else if (rd_en_i) begin
        rd_data_q <= mem_q[rd_addr_i];
      end
    end
    assign rd_data_o = rd_data_q;
  end

endmodule

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with FWFT option, threshold flags and sticky errors
// Define FIFO_SYNC_PEAK_EN to build the peak-occupancy monitor; otherwise peak_usedw_o is 0.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_BITS     = 4,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = 2**ADDR_BITS-2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  wr_req_i,
  input  logic                  rd_req_i,
  input  logic                  clr_err_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  data_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_BITS:0]    usedw_o,
  output logic [PERC_WIDTH-1:0] perc_full_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic [ADDR_BITS:0]    peak_usedw_o
);

  localparam int FIFO_DEPTH = 2**ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_W  = (ADDR_BITS+1)'(FIFO_DEPTH);
  localparam logic [ADDR_BITS:0] AFULL_W  = (ADDR_BITS+1)'(AFULL_THRESH);
  localparam logic [ADDR_BITS:0] AEMPTY_W = (ADDR_BITS+1)'(AEMPTY_THRESH);

  if (AFULL_THRESH < 0 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
    $error("fifo_sync: AFULL_THRESH outside 0..FIFO_DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH) begin : g_bad_aempty
    $error("fifo_sync: AEMPTY_THRESH outside 0..FIFO_DEPTH");
  end

  logic [ADDR_BITS-1:0]  wr_ptr_q, rd_ptr_q;
  logic [ADDR_BITS:0]    usedw_q, usedw_d;
  logic                  full_q, empty_q, afull_q, aempty_q, dv_q;
  logic [PERC_WIDTH-1:0] perc_q;
  err_flags_t            err_q, err_d;
  logic                  wr_acc, rd_acc;

  always_comb begin
    wr_acc          = en_i & wr_req_i & ~full_q;
    rd_acc          = en_i & rd_req_i & ~empty_q;
    usedw_d         = usedw_q + (ADDR_BITS+1)'(wr_acc) - (ADDR_BITS+1)'(rd_acc);
    // A new error in the same cycle as clr_err must survive the clear.
    err_d.overflow  = (err_q.overflow  & ~clr_err_i) | (wr_req_i & full_q);
    err_d.underflow = (err_q.underflow & ~clr_err_i) | (rd_req_i & empty_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      perc_q   <= '0;
      err_q    <= '0;
      dv_q     <= 1'b0;
    end else begin
      dv_q <= rd_acc;
      if (en_i) begin
        if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_BITS'(1);
        if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_BITS'(1);
        usedw_q  <= usedw_d;
        full_q   <= (usedw_d == DEPTH_W);
        empty_q  <= (usedw_d == '0);
        afull_q  <= (usedw_d >= AFULL_W);
        aempty_q <= (usedw_d <= AEMPTY_W);
        perc_q   <= f_perc(32'(usedw_d), ADDR_BITS);
        err_q    <= err_d;
      end
    end
  end

  fifo_sync_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS),
    .ASYNC_READ (FWFT != 0)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in_i),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out_o)
  );

`ifdef FIFO_SYNC_PEAK_EN
  logic [ADDR_BITS:0] peak_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      peak_q <= '0;
    end else if (en_i) begin
      if (clr_err_i || (usedw_d > peak_q)) peak_q <= usedw_d;
    end
  end
  assign peak_usedw_o = peak_q;
`else
  assign peak_usedw_o = '0;
`endif

  assign data_valid_o   = (FWFT != 0) ? ~empty_q : dv_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign usedw_o        = usedw_q;
  assign perc_full_o    = perc_q;
  assign overflow_o     = err_q.overflow;
  assign underflow_o    = err_q.underflow;

endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - queue-model bench driving a standard and an FWFT fifo_sync side by side
module tb_fifo_sync;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, en, wr_req, rd_req, clr_err;
  logic [31:0] data_in;

  logic [1:0][31:0] dout;
  logic [1:0][4:0]  usedw, peak;
  logic [1:0][6:0]  perc;
  logic [1:0]       dv, full, empty, afull, aempty, ovf, unf;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_sync #(.DATA_WIDTH(32), .ADDR_BITS(4), .FWFT(g)) u_dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .wr_req_i(wr_req), .rd_req_i(rd_req),
      .clr_err_i(clr_err), .data_in_i(data_in), .data_out_o(dout[g]), .data_valid_o(dv[g]),
      .full_o(full[g]), .empty_o(empty[g]), .almost_full_o(afull[g]), .almost_empty_o(aempty[g]),
      .usedw_o(usedw[g]), .perc_full_o(perc[g]), .overflow_o(ovf[g]), .underflow_o(unf[g]),
      .peak_usedw_o(peak[g])
    );
  end

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the sticky and peak state.
  logic [31:0] mq[$];
  bit          m_over, m_under, m_dv;
  logic [31:0] m_dout;
  int          m_peak;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_over = 0; m_under = 0; m_dv = 0; m_dout = '0; m_peak = 0;
    end else begin
      bit was_full, was_empty, wa, ra;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      wa = en && wr_req && !was_full;
      ra = en && rd_req && !was_empty;
      m_dv = ra;
      if (en) begin
        m_over  = (m_over  && !clr_err) || (wr_req && was_full);
        m_under = (m_under && !clr_err) || (rd_req && was_empty);
      end
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(data_in);
      if (en) m_peak = clr_err ? mq.size() : ((mq.size() > m_peak) ? mq.size() : m_peak);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int n;
      int exp_peak;
      n = mq.size();
`ifdef FIFO_SYNC_PEAK_EN
      exp_peak = m_peak;
`else
      exp_peak = 0;
`endif
      for (int g = 0; g < 2; g++) begin
        chk("usedw",     g, 64'(usedw[g]),  64'(n));
        chk("full",      g, 64'(full[g]),   64'(n == DEPTH));
        chk("empty",     g, 64'(empty[g]),  64'(n == 0));
        chk("afull",     g, 64'(afull[g]),  64'(n >= 14));
        chk("aempty",    g, 64'(aempty[g]), 64'(n <= 2));
        chk("perc",      g, 64'(perc[g]),   64'((n * 100) / DEPTH));
        chk("overflow",  g, 64'(ovf[g]),    64'(m_over));
        chk("underflow", g, 64'(unf[g]),    64'(m_under));
        chk("peak",      g, 64'(peak[g]),   64'(exp_peak));
      end
      chk("std_valid", 0, 64'(dv[0]),   64'(m_dv));
      chk("std_data",  0, 64'(dout[0]), 64'(m_dout));
      chk("fwft_valid", 1, 64'(dv[1]), 64'(n != 0));
      if (n != 0) chk("fwft_data", 1, 64'(dout[1]), 64'(mq[0]));
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [31:0] d,
                     input bit e = 1'b1, input bit c = 1'b0, input bit rs = 1'b0);
    wr_req = w; rd_req = r; data_in = d; en = e; clr_err = c; rst = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; wr_req = 1'b0; rd_req = 1'b0; clr_err = 1'b0; data_in = '0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    cyc(0, 0, 0, 1, 0, 1);
    chk("rst_usedw", 0, 64'(usedw[0]), 64'd0);
    chk("rst_empty", 0, 64'(empty[0]), 64'd1);
    chk("rst_aempty", 0, 64'(aempty[0]), 64'd1);
    chk("rst_dout", 0, 64'(dout[0]), 64'd0);
    chk("rst_valid", 0, 64'(dv[0]), 64'd0);

    cyc(1, 0, 32'hA5A5_0001);
    chk("fwft_first", 1, 64'(dout[1]), 64'hA5A5_0001);
    chk("fwft_first_v", 1, 64'(dv[1]), 64'd1);
    chk("std_nov", 0, 64'(dv[0]), 64'd0);
    cyc(0, 1, 0);
    chk("std_first", 0, 64'(dout[0]), 64'hA5A5_0001);
    chk("std_first_v", 0, 64'(dv[0]), 64'd1);
    cyc(0, 0, 0);
    chk("std_v_drop", 0, 64'(dv[0]), 64'd0);

    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 32'(i));
      if (i == 12) chk("afull_13", 0, 64'(afull[0]), 64'd0);
      if (i == 13) chk("afull_14", 0, 64'(afull[0]), 64'd1);
      if (i == 14) chk("full_15", 0, 64'(full[0]), 64'd0);
    end
    chk("full_16", 0, 64'(full[0]), 64'd1);
    chk("usedw_16", 0, 64'(usedw[0]), 64'd16);
    chk("perc_16", 0, 64'(perc[0]), 64'd100);
    cyc(1, 0, 32'hDEAD_BEEF);
    chk("ovf_set", 0, 64'(ovf[0]), 64'd1);
    chk("ovf_usedw", 0, 64'(usedw[0]), 64'd16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0);
      chk("seq_std", 0, 64'(dout[0]), 64'(i));
      if (i < 15) chk("seq_fwft", 1, 64'(dout[1]), 64'(i + 1));
    end
    cyc(0, 0, 0, 1, 1);

    for (int i = 0; i < 8; i++) cyc(1, 0, 32'(100 + i));
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 32'(200 + k));
      chk("rw_usedw", 0, 64'(usedw[0]), 64'd8);
      chk("rw_perc", 0, 64'(perc[0]), 64'd50);
    end
    for (int i = 0; i < 8; i++) cyc(0, 1, 0);

    cyc(0, 1, 0);
    chk("unf_set", 0, 64'(unf[0]), 64'd1);
    cyc(0, 1, 0, 1, 1);
    chk("unf_set_wins", 0, 64'(unf[0]), 64'd1);
    cyc(0, 0, 0, 1, 1);
    chk("unf_clr", 0, 64'(unf[0]), 64'd0);

    for (int i = 0; i < 12; i++) cyc(1, 0, $urandom);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, $urandom, 0, 1);
      chk("en0_usedw", 0, 64'(usedw[0]), 64'd12);
      chk("en0_ovf", 0, 64'(ovf[0]), 64'd0);
      chk("en0_unf", 0, 64'(unf[0]), 64'd0);
    end
    cyc(1, 1, 0, 1, 0, 1);
    chk("mid_rst_usedw", 0, 64'(usedw[0]), 64'd0);
    chk("mid_rst_empty", 0, 64'(empty[0]), 64'd1);
    chk("mid_rst_aempty", 0, 64'(aempty[0]), 64'd1);

    for (int i = 0; i < 11; i++) cyc(1, 0, $urandom);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0);
`ifdef FIFO_SYNC_PEAK_EN
    chk("peak_11", 0, 64'(peak[0]), 64'd11);
    cyc(0, 0, 0, 1, 1);
    chk("peak_clr", 0, 64'(peak[0]), 64'd3);
`else
    chk("peak_off", 0, 64'(peak[0]), 64'd0);
    cyc(0, 0, 0, 1, 1);
    chk("peak_off_clr", 0, 64'(peak[0]), 64'd0);
`endif

    for (int k = 0; k < 3000; k++) begin
      int bias;
      bias = ((k / 300) % 2 == 0) ? 70 : 30;
      cyc(($urandom % 100) < bias, ($urandom % 100) < (100 - bias), $urandom,
          ($urandom % 8) != 0, ($urandom % 20) == 0, ($urandom % 400) == 0);
    end
    cyc(0, 0, 0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
- Single-clock, parametrised FIFO; next generation of the team's dual-clock fifo for same-domain buffering, e.g. between the ADC capture and packetiser stages.
- Adds a selectable first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow flags.
- Adds a registered percentage-full output and an optional peak-occupancy monitor.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_BITS, 4, log2 of depth; depth FIFO_DEPTH = 2**ADDR_BITS (derived localparam, power of two only).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- AFULL_THRESH, 2**ADDR_BITS-2, almost_full asserts when usedw >= value.
- AEMPTY_THRESH, 2, almost_empty asserts when usedw <= value.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; low freezes all state.
- wr_req  in  1  write request.
- rd_req  in  1  read request (pop/ack in FWFT mode).
- clr_err  in  1  clears overflow, underflow and peak_usedw.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data.
- data_valid  out  1  data_out holds valid read data.
- full  out  1  usedw == FIFO_DEPTH.
- empty  out  1  usedw == 0.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- usedw  out  ADDR_BITS+1  occupancy, 0..FIFO_DEPTH.
- perc_full  out  7  occupancy percent, 0..100.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- peak_usedw  out  ADDR_BITS+1  high-water mark (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - wr_ptr = rd_ptr = 0; usedw = 0; perc_full = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - data_out = 0, data_valid = 0.
  - overflow = 0, underflow = 0, peak_usedw = 0.
  - RAM contents are not reset.
- Reset mid-operation discards all stored words; the first read after reset sees only post-reset writes.
- en = 0: no pointer, flag, or data_out change; wr_req/rd_req are ignored and never set the error flags; data_valid is forced to 0 in standard mode.
- Accept rules:
  - wr_acc = en & wr_req & ~full.
  - rd_acc = en & rd_req & ~empty.
  - Both evaluated on pre-edge flags.
- Simultaneous wr_acc and rd_acc: both occur and usedw is unchanged.
- A write while full is dropped, even if a read happens in the same cycle.
- Pointers are ADDR_BITS wide and wrap modulo FIFO_DEPTH.
- usedw_next = usedw + wr_acc - rd_acc. All flags and perc_full are registered from usedw_next, so they update on the same edge as the access.
- perc_full = (usedw_next * 100) >> ADDR_BITS, truncating, with a 7-bit result (16 deep: 8 words -> 50, 16 -> 100, 1 -> 6).
- Standard mode (FWFT = 0):
  - data_out <= mem[rd_ptr] on rd_acc, giving 1-cycle read latency.
  - data_valid is 1 for exactly the cycle after each rd_acc.
  - data_out holds its last value otherwise.
- FWFT mode (FWFT = 1):
  - data_out = mem[rd_ptr] combinationally; data_valid = ~empty.
  - A word written at edge N is visible after edge N.
  - rd_acc pops, and the next word appears after that edge.
- Overflow/underflow:
  - overflow is set on en & wr_req & full; underflow is set on en & rd_req & empty.
  - clr_err clears both; if a set and clr_err occur in the same cycle, the set wins.
- Threshold parameters outside 0..FIFO_DEPTH are illegal; the block flags them with a simulation $error at elaboration.

Optional Feature:
- Macro: FIFO_SYNC_PEAK_EN.
- Defined: peak_usedw registers max(peak_usedw, usedw_next) each enabled cycle; rst or clr_err reloads it with usedw_next.
- Undefined: peak_usedw is tied to 0 and no comparator logic is generated; the port always exists.

Decomposition:
- Package fifo_pkg holds:
  - PERC_SCALE = 100 and PERC_WIDTH = 7.
  - Function f_perc(usedw, addr_bits).
  - Typedef for the error-flag pair {overflow, underflow}.
- One sub-module, fifo_sync_ram: DATA_WIDTH x 2**ADDR_BITS array, one write port, with a read port selectable as registered (standard) or asynchronous (FWFT) via a parameter.

Test Plan (DATA_WIDTH = 32, ADDR_BITS = 4, AFULL = 14, AEMPTY = 2):
- Reset, then write 0xA5A5_0001 and read it back:
  - FWFT = 0: data_valid high one cycle after rd_req, data_out = 0xA5A5_0001.
  - FWFT = 1: data_out = 0xA5A5_0001 with data_valid high the cycle after the write.
- Write 16 words (values 0..15):
  - almost_full rises on the 14th write; full rises on the 16th; usedw = 16; perc_full = 100.
  - A 17th write sets overflow, and the data is dropped.
  - Read all 16 and check the sequence 0..15 in order.
- With usedw = 8, assert wr_req and rd_req together for 5 cycles -> usedw stays 8, perc_full = 50, output order preserved.
- rd_req while empty -> underflow = 1.
  - clr_err in a cycle with a new underflow -> underflow stays 1.
  - clr_err alone -> underflow = 0.
- Write 12 words, then hold en = 0 for 4 cycles with wr_req and rd_req high -> usedw stays 12, no error flags set.
  - Assert rst mid-stream -> usedw = 0, empty = 1, almost_empty = 1 next cycle.
- With FIFO_SYNC_PEAK_EN defined: fill to 11, drain to 3 -> peak_usedw = 11; clr_err -> peak_usedw = 3.
  - Undefined -> peak_usedw stays 0 throughout.
